// File: rtl/aixh_mxc_left_ptile_wbcol_if.sv
// Handshake bundle between the left ptile cell, the writeback collector and the output buffer.
// The collector takes the slave view: it consumes cell words and drives write requests.
interface aixh_mxc_left_ptile_wbcol_if #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 16
);
  logic              i_lqc_vld;
  logic [DWIDTH-1:0] i_lqc_dat;
  logic              o_wr_vld;
  logic [AWIDTH-1:0] o_wr_addr;
  logic [DWIDTH-1:0] o_wr_dat;
  logic              i_wr_rdy;

  modport slave (
    input  i_lqc_vld, i_lqc_dat, i_wr_rdy,
    output o_wr_vld, o_wr_addr, o_wr_dat
  );

  modport master (
    output i_lqc_vld, i_lqc_dat, i_wr_rdy,
    input  o_wr_vld, o_wr_addr, o_wr_dat
  );
endinterface

// File: rtl/aixh_mxc_left_ptile_wbcol.sv
// Writeback collector: buffers packed cell words in a show-ahead FIFO and issues them as
// addressed write requests for one programmed run, flagging overflowed and stray words.
module aixh_mxc_left_ptile_wbcol #(
  parameter int DWIDTH     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int AWIDTH     = 16
) (
  input  logic                        aixh_core_clk2x,
  input  logic                        aixh_core_rst2x,
  input  logic                        i_cfg_start,
  input  logic [AWIDTH-1:0]           i_cfg_base,
  input  logic [AWIDTH-1:0]           i_cfg_stride,
  input  logic [15:0]                 i_cfg_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_ovf,
  output logic                        o_stray,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  aixh_mxc_left_ptile_wbcol_if.slave  wb
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] stride_q, addr_q;
  logic [15:0]       count_q, accept_cnt;
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       level;
  logic              ovf_q, stray_q;
  logic              start_acc, run_word, full, push, pop, ovf_evt, stray_evt;

  assign start_acc = (state == IDLE) && i_cfg_start;
  assign run_word  = (state == RUN) && wb.i_lqc_vld && (accept_cnt != count_q);
  assign full      = (level == LVL_FULL);
  assign pop       = (level != '0) && wb.i_wr_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign push      = run_word && (!full || pop);
  assign ovf_evt   = run_word && full && !pop;
  assign stray_evt = wb.i_lqc_vld && ((state != RUN) || (accept_cnt == count_q));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_cfg_start) state_nxt = (i_cfg_count == 16'd0) ? DONE : RUN;
      RUN:   if (accept_cnt == count_q) state_nxt = DRAIN;
      DRAIN: if ((level == '0) || ((level == (PW+1)'(1)) && pop)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
    if (aixh_core_rst2x) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
    if (aixh_core_rst2x) begin
      stride_q   <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      accept_cnt <= '0;
      ovf_q      <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        stride_q   <= i_cfg_stride;
        count_q    <= i_cfg_count;
        accept_cnt <= '0;
        addr_q     <= i_cfg_base;
        ovf_q      <= 1'b0;
        stray_q    <= 1'b0;
      end else begin
        if (run_word) accept_cnt <= accept_cnt + 16'd1;
        if (pop)      addr_q     <= addr_q + stride_q;
        if (ovf_evt)  ovf_q      <= 1'b1;
      end
      // Placed after the start clear so a word in the start cycle still counts as stray.
      if (stray_evt) stray_q <= 1'b1;
    end
  end

  always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
    if (aixh_core_rst2x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wb.i_lqc_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_ovf        = ovf_q;
  assign o_stray      = stray_q;
  assign o_level      = level;
  assign wb.o_wr_vld  = (level != '0);
  assign wb.o_wr_addr = addr_q;
  assign wb.o_wr_dat  = mem[rd_ptr];

endmodule

// File: tb/tb_aixh_mxc_left_ptile_wbcol.sv
// Bench for the writeback collector: table of programmed runs plus hand sequences,
// with a write scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_aixh_mxc_left_ptile_wbcol;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_base = '0, cfg_stride = '0, cfg_count = '0;
  logic        busy, done, ovf, stray;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] base, stride, count;
    int          nwords, rdy_from;
    bit          dbl, exp_ovf, exp_stray;
    int          exp_level;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] dat;
  } wr_t;

  wr_t  sb[$];
  vec_t vecs[5];

  aixh_mxc_left_ptile_wbcol_if #(.DWIDTH(64), .AWIDTH(16)) ifc ();

  aixh_mxc_left_ptile_wbcol #(.DWIDTH(64), .FIFO_DEPTH(8), .AWIDTH(16)) dut (
    .aixh_core_clk2x (clk),
    .aixh_core_rst2x (rst),
    .i_cfg_start     (cfg_start),
    .i_cfg_base      (cfg_base),
    .i_cfg_stride    (cfg_stride),
    .i_cfg_count     (cfg_count),
    .o_busy          (busy),
    .o_done          (done),
    .o_ovf           (ovf),
    .o_stray         (stray),
    .o_level         (level),
    .wb              (ifc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every transfer seen on the write port must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && ifc.o_wr_vld && ifc.i_wr_rdy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr %h with no write expected", ifc.o_wr_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_output("wr_addr", 64'(ifc.o_wr_addr), 64'(e.addr));
        check_output("wr_dat", ifc.o_wr_dat, e.dat);
      end
    end
  end

  task automatic wait_done(input string tag);
    int nd = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (!busy && nd > 0) break;
    end
    check_output({tag, "_done_pulses"}, 64'(nd), 64'd1);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int          occ = 0;
    bit          pop, push;
    logic [15:0] exp_addr;
    logic [63:0] dat;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    step();
    cfg_start  = 1'b1;
    cfg_base   = v.base;
    cfg_stride = v.stride;
    cfg_count  = v.count;
    step();
    cfg_start = 1'b0;
    exp_addr  = v.base;
    for (int k = 0; k < v.nwords; k++) begin
      dat = {$urandom(), $urandom()};
      ifc.i_lqc_vld = 1'b1;
      ifc.i_lqc_dat = dat;
      ifc.i_wr_rdy  = (k >= v.rdy_from);
      if (k == 0 && v.dbl) begin
        cfg_start = 1'b1;
        cfg_base  = 16'hDEAD;
        cfg_count = 16'd1;
      end
      pop  = (occ > 0) && ifc.i_wr_rdy;
      push = (k < int'(v.count)) && (occ < 8 || pop);
      if (push) begin
        sb.push_back('{exp_addr, dat});
        exp_addr = exp_addr + v.stride;
      end
      occ = occ + int'(push) - int'(pop);
      step();
      cfg_start = 1'b0;
    end
    ifc.i_lqc_vld = 1'b0;
    if (v.exp_level >= 0) check_output({tag, "_level"}, 64'(level), 64'(v.exp_level));
    ifc.i_wr_rdy = 1'b1;
    wait_done(tag);
    check_output({tag, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
    check_output({tag, "_stray"}, 64'(stray), 64'(v.exp_stray));
    check_output({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0100, 16'd4,    16'd6,  6,  0,  1'b0, 1'b0, 1'b0, -1};
    vecs[1] = '{16'h2000, 16'd8,    16'd10, 10, 99, 1'b0, 1'b1, 1'b0, 8};
    vecs[2] = '{16'hFFFC, 16'd4,    16'd2,  2,  0,  1'b0, 1'b0, 1'b0, -1};
    vecs[3] = '{16'h0040, 16'd1,    16'd3,  5,  0,  1'b1, 1'b0, 1'b1, -1};
    vecs[4] = '{16'h0500, 16'h0010, 16'd9,  9,  8,  1'b0, 1'b0, 1'b0, 8};

    ifc.i_lqc_vld = 1'b0;
    ifc.i_lqc_dat = '0;
    ifc.i_wr_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_vld", 64'(ifc.o_wr_vld), 64'd0);
    check_output("rst_level", 64'(level), 64'd0);
    check_output("rst_addr", 64'(ifc.o_wr_addr), 64'd0);
    check_output("rst_dat", ifc.o_wr_dat, 64'd0);
    step();
    rst = 1'b0;

    // Zero-count start: done one cycle later, no write request.
    step();
    cfg_start = 1'b1;
    cfg_count = 16'd0;
    step();
    cfg_start = 1'b0;
    @(negedge clk);
    check_output("zc_done", 64'(done), 64'd1);
    check_output("zc_vld", 64'(ifc.o_wr_vld), 64'd0);
    @(negedge clk);
    check_output("zc_done_clear", 64'(done), 64'd0);
    check_output("zc_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

    // Word while idle is stray and produces no write.
    step();
    ifc.i_lqc_vld = 1'b1;
    ifc.i_lqc_dat = 64'h1234_5678_9ABC_DEF0;
    step();
    ifc.i_lqc_vld = 1'b0;
    check_output("idle_stray", 64'(stray), 64'd1);
    check_output("idle_vld", 64'(ifc.o_wr_vld), 64'd0);

    // Reset in the middle of a run with words still buffered.
    cfg_start  = 1'b1;
    cfg_base   = 16'h0040;
    cfg_stride = 16'd1;
    cfg_count  = 16'd5;
    ifc.i_wr_rdy = 1'b0;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ifc.i_lqc_vld = 1'b1;
      ifc.i_lqc_dat = {$urandom(), $urandom()};
      step();
    end
    ifc.i_lqc_vld = 1'b0;
    check_output("mid_level", 64'(level), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_busy", 64'(busy), 64'd0);
    check_output("mid_done", 64'(done), 64'd0);
    check_output("mid_ovf", 64'(ovf), 64'd0);
    check_output("mid_stray", 64'(stray), 64'd0);
    check_output("mid_vld", 64'(ifc.o_wr_vld), 64'd0);
    check_output("mid_addr", 64'(ifc.o_wr_addr), 64'd0);
    check_output("mid_dat", ifc.o_wr_dat, 64'd0);
    check_output("mid_level_rst", 64'(level), 64'd0);
    sb.delete();
    step();
    rst = 1'b0;
    ifc.i_wr_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("post_rst_done", 64'(done), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aixh_mxc_left_ptile_wbcol.md
# aixh_mxc_left_ptile_wbcol

Writeback collector that sits directly downstream of a left processing-tile cell in the MxConv array. It accepts the cell's packed 64-bit output words (valid-only, no backpressure), buffers them in a small FIFO, and issues them as addressed write requests with a valid/ready handshake toward the output buffer. It sequences one programmed output run at a time and flags dropped or unexpected words.

## Interface
Parameters:
- DWIDTH, 64, packed word width; equals the cell's packed output width.
- FIFO_DEPTH, 8, buffer entries; power of two, >= 2.
- AWIDTH, 16, write address width.

Ports:
- aixh_core_clk2x  in  1  core 2x clock; all logic on its rising edge.
- aixh_core_rst2x  in  1  asynchronous, active-high reset.
- i_cfg_start  in  1  one-cycle run start pulse.
- i_cfg_base  in  AWIDTH  first write address.
- i_cfg_stride  in  AWIDTH  address increment per written word.
- i_cfg_count  in  16  number of words in the run.
- o_busy  out  1  high while the FSM is not IDLE.
- o_done  out  1  one-cycle pulse when the run has fully written.
- o_ovf  out  1  sticky; a word arrived while the FIFO was full.
- o_stray  out  1  sticky; a word arrived outside RUN or beyond i_cfg_count.
- i_lqc_vld  in  1  packed word valid from the cell.
- i_lqc_dat  in  DWIDTH  packed word from the cell.
- o_wr_vld  out  1  write request valid.
- o_wr_addr  out  AWIDTH  write address.
- o_wr_dat  out  DWIDTH  write data.
- i_wr_rdy  in  1  sink ready; a transfer occurs when o_wr_vld & i_wr_rdy.
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on i_cfg_start.
  - On start, latch base, stride and count; clear o_ovf and o_stray; clear the accept counter; set the address register to base.
  - i_cfg_start is ignored in any state other than IDLE.
- When i_cfg_start arrives with i_cfg_count==0, go IDLE -> DONE, with no writes issued.
- In RUN, each i_lqc_vld is handled as follows:
  - FIFO not full: push the word and increment the accept counter.
  - FIFO full: drop the word and set o_ovf. The accept counter still increments, so the run length stays aligned with the producer.
  - Full with a simultaneous pop: the push is accepted and o_ovf is not set.
- RUN -> DRAIN in the cycle after the accept counter reaches the latched count.
- DRAIN -> DONE when the FIFO is empty and no transfer is pending.
- DONE -> IDLE after one cycle; o_done is high during DONE.
- An i_lqc_vld in IDLE, DRAIN or DONE drops the word and sets o_stray.
- The FIFO is show-ahead:
  - o_wr_vld = FIFO not empty.
  - o_wr_dat = head entry.
  - o_wr_addr = address register.
- On each transfer: pop the head, and set address register = address register + stride, modulo 2^AWIDTH (wrap-around is silent).
- Stalled request rule: o_wr_vld, o_wr_addr and o_wr_dat stay stable while i_wr_rdy is low.
- o_level tracks the number of pushes minus pops. It reaches FIFO_DEPTH when full.

## Timing
- Reset values: o_busy=0, o_done=0, o_ovf=0, o_stray=0, o_wr_vld=0, o_wr_addr=0, o_wr_dat=0, o_level=0; FSM in IDLE; FIFO pointers at 0.
- A reset asserted mid-run aborts immediately. Buffered words are discarded and no o_done is produced.
- Start latency: the start in cycle N puts the FSM in RUN at N+1. An i_lqc_vld in cycle N itself is stray.
- Push-to-request latency: a word pushed at N into an empty FIFO gives o_wr_vld=1 at N+1.
- Throughput: with i_wr_rdy held high, one word per cycle is sustained and the FIFO never fills.
- Done timing: a last transfer at cycle N gives DONE at N+1 (o_done=1) and IDLE with o_busy=0 at N+2, provided RUN has already exited.
- A zero-count start at N gives o_done=1 at N+1.

## Test plan
- Nominal run: base=0x0100, stride=4, count=6; six consecutive vld words D0..D5 with rdy=1 -> writes at addresses 0x100, 0x104, ..., 0x114 with data D0..D5 in order; o_done pulses exactly once; o_ovf=0 and o_stray=0.
- Backpressure/overflow: DEPTH=8, count=10, rdy=0 throughout the input burst -> words 0..7 are buffered, words 8 and 9 are dropped; o_ovf=1; o_level=8; after rdy is raised, exactly 8 writes occur and then o_done.
- Full with simultaneous pop: FIFO full, with vld and a transfer in the same cycle -> the word is accepted, o_level stays 8, and o_ovf stays 0.
- Address wrap and zero count: base=0xFFFC, stride=4, count=2 -> writes at 0xFFFC then 0x0000. A separate start with count=0 gives o_done one cycle later and no o_wr_vld.
- Stray and protocol checks:
  - vld in IDLE, and vld after count has been reached -> o_stray=1 with no extra writes.
  - A second i_cfg_start during RUN is ignored.
  - Asserting aixh_core_rst2x mid-run returns all outputs to their reset values without waiting for a clock edge.
